// File: rtl/data_memory_pkg.sv
// Shared types and helpers for the sized, byte-addressed data memory.
// Lane masks are computed for the widest supported word and sliced by users.
package data_memory_pkg;

  localparam int MAX_LANES = 4;

  typedef enum logic [1:0] {
    BYTE    = 2'd0,
    HALF    = 2'd1,
    WORD    = 2'd2,
    ILLEGAL = 2'd3
  } mem_size_e;

  typedef enum logic {
    IDLE  = 1'b0,
    SPLIT = 1'b1
  } mem_state_e;

  function automatic int size_bytes(input mem_size_e size);
    return 1 << size;
  endfunction

  // Lanes o..o+n-1 across two consecutive words: low half is beat 0, high half beat 1.
  function automatic logic [2*MAX_LANES-1:0] lane_enables(input logic [1:0] offset,
                                                          input mem_size_e size);
    logic [2*MAX_LANES-1:0] base;
    case (size)
      BYTE:    base = (2*MAX_LANES)'(4'b0001);
      HALF:    base = (2*MAX_LANES)'(4'b0011);
      WORD:    base = (2*MAX_LANES)'(4'b1111);
      default: base = '0;
    endcase
    return base << offset;
  endfunction

endpackage

// File: rtl/byte_lane_ram.sv
// Single-port synchronous RAM, LANES bytes wide, with per-lane write enables.
// Read data is registered and returns the contents before any same-cycle write.
module byte_lane_ram #(
  parameter int WORD_W     = 14,
  parameter int LANES      = 4,
  parameter int BYTE_WIDTH = 8
) (
  input  logic                          clk,
  input  logic                          en,
  input  logic [WORD_W-1:0]             addr,
  input  logic [LANES-1:0]              we,
  input  logic [LANES*BYTE_WIDTH-1:0]   wdata,
  output logic [LANES*BYTE_WIDTH-1:0]   rdata
);

  logic [LANES*BYTE_WIDTH-1:0] mem [2**WORD_W];

  // NOTE: no reset on the array or read register; a reset loop over every word would not map onto RAM macros.
  always_ff @(posedge clk) begin
    if (en) begin
      for (int i = 0; i < LANES; i++) begin
        if (we[i]) mem[addr][i*BYTE_WIDTH +: BYTE_WIDTH] <= wdata[i*BYTE_WIDTH +: BYTE_WIDTH];
      end
      rdata <= mem[addr];
    end
  end

endmodule

// File: rtl/sized_data_memory.sv
// Byte/half/word load-store memory; accesses that straddle a word boundary
// are issued as two beats, with the read beats merged before extension.
module sized_data_memory
  import data_memory_pkg::*;
#(
  parameter int ADDR_WIDTH = 16,
  parameter int LANES      = 4,
  parameter int BYTE_WIDTH = 8
) (
  input  logic                        clk,
  input  logic                        rst_n,
  input  logic                        read_en,
  input  logic                        write_en,
  input  logic [ADDR_WIDTH-1:0]       addr,
  input  logic [1:0]                  size,
  input  logic                        signed_rd,
  input  logic [BYTE_WIDTH*LANES-1:0] data_in,
  output logic                        ready,
  output logic [BYTE_WIDTH*LANES-1:0] data_out,
  output logic                        rsp_valid,
  output logic                        err
);

  localparam int DATA_W = BYTE_WIDTH * LANES;
  localparam int OFF_W  = $clog2(LANES);
  localparam int WORD_W = ADDR_WIDTH - OFF_W;

  mem_state_e state;

  // Request decode
  mem_size_e              req_size;
  logic [OFF_W-1:0]       req_off;
  logic [WORD_W-1:0]      req_word;
  logic [2*MAX_LANES-1:0] req_mask;
  logic [2*DATA_W-1:0]    req_wide;
  logic                   accept, legal, is_split;

  assign req_size = mem_size_e'(size);
  assign req_off  = addr[OFF_W-1:0];
  assign req_word = addr[ADDR_WIDTH-1:OFF_W];
  assign req_mask = lane_enables(2'(req_off), req_size);
  assign req_wide = {{DATA_W{1'b0}}, data_in} << (int'(req_off) * BYTE_WIDTH);
  assign accept   = ready && (read_en || write_en);
  assign legal    = (req_size != ILLEGAL) && (size_bytes(req_size) <= LANES);
  assign is_split = (int'(req_off) + size_bytes(req_size)) > LANES;

  // Beat-1 context captured when a split request is accepted
  logic [WORD_W-1:0] b1_word;
  logic [LANES-1:0]  b1_we;
  logic [DATA_W-1:0] b1_wdata;
  logic              b1_write;

  // Response context and beat-0 hold register
  logic [OFF_W-1:0]  rsp_off;
  mem_size_e         rsp_size;
  logic              rsp_signed, rsp_split;
  logic [DATA_W-1:0] hold_q, data_q, data_result;

  logic              ram_en;
  logic [WORD_W-1:0] ram_addr;
  logic [LANES-1:0]  ram_we;
  logic [DATA_W-1:0] ram_wdata, ram_rdata;

  // NOTE: every always_comb output gets a default first so no path leaves it unassigned (no latch).
  always_comb begin
    ram_en    = 1'b0;
    ram_addr  = req_word;
    ram_we    = '0;
    ram_wdata = req_wide[DATA_W-1:0];
    if (state == SPLIT) begin
      ram_en    = 1'b1;
      ram_addr  = b1_word;
      ram_we    = b1_write ? b1_we : '0;
      ram_wdata = b1_wdata;
    end else if (accept && legal) begin
      ram_en = 1'b1;
      ram_we = write_en ? req_mask[LANES-1:0] : '0;
    end
  end

  byte_lane_ram #(
    .WORD_W     (WORD_W),
    .LANES      (LANES),
    .BYTE_WIDTH (BYTE_WIDTH)
  ) u_ram (
    .clk   (clk),
    .en    (ram_en),
    .addr  (ram_addr),
    .we    (ram_we),
    .wdata (ram_wdata),
    .rdata (ram_rdata)
  );

  // Align the read bytes to bit 0, then zero- or sign-fill above the access size.
  always_comb begin
    logic [2*DATA_W-1:0] pair;
    logic [DATA_W-1:0]   merged;
    int                  nbytes;
    logic                sign;
    pair        = rsp_split ? {ram_rdata, hold_q} : {{DATA_W{1'b0}}, ram_rdata};
    merged      = DATA_W'(pair >> (int'(rsp_off) * BYTE_WIDTH));
    nbytes      = size_bytes(rsp_size);
    sign        = 1'b0;
    data_result = '0;
    for (int i = 0; i < LANES; i++) begin
      if (i == nbytes - 1) sign = rsp_signed & merged[i*BYTE_WIDTH + BYTE_WIDTH - 1];
    end
    for (int i = 0; i < LANES; i++) begin
      data_result[i*BYTE_WIDTH +: BYTE_WIDTH] = (i < nbytes) ? merged[i*BYTE_WIDTH +: BYTE_WIDTH]
                                                             : {BYTE_WIDTH{sign}};
    end
  end

  assign ready    = (state == IDLE);
  assign data_out = rsp_valid ? data_result : data_q;

  // NOTE: sequential state uses non-blocking assignments so every register samples pre-edge values.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state      <= IDLE;
      rsp_valid  <= 1'b0;
      err        <= 1'b0;
      hold_q     <= '0;
      data_q     <= '0;
      rsp_off    <= '0;
      rsp_size   <= BYTE;
      rsp_signed <= 1'b0;
      rsp_split  <= 1'b0;
      b1_word    <= '0;
      b1_we      <= '0;
      b1_wdata   <= '0;
      b1_write   <= 1'b0;
    end else begin
      rsp_valid <= 1'b0;
      err       <= 1'b0;
      if (rsp_valid) data_q <= data_result;
      case (state)
        IDLE: begin
          if (accept) begin
            if (!legal) begin
              err <= 1'b1;
            end else if (is_split) begin
              state      <= SPLIT;
              b1_word    <= req_word + 1'b1;
              b1_we      <= req_mask[2*LANES-1:LANES];
              b1_wdata   <= req_wide[2*DATA_W-1:DATA_W];
              b1_write   <= write_en;
              rsp_off    <= req_off;
              rsp_size   <= req_size;
              rsp_signed <= signed_rd;
              rsp_split  <= 1'b1;
            end else if (!write_en) begin
              rsp_valid  <= 1'b1;
              rsp_off    <= req_off;
              rsp_size   <= req_size;
              rsp_signed <= signed_rd;
              rsp_split  <= 1'b0;
            end
          end
        end
        SPLIT: begin
          state  <= IDLE;
          hold_q <= ram_rdata;
          if (!b1_write) rsp_valid <= 1'b1;
        end
        default: state <= IDLE;
      endcase
    end
  end

endmodule
